// File: rtl/deserializer_fsm.sv
// rtl/deserializer_fsm.sv - serial-to-parallel word assembler with a ready/valid output handshake
// Bits are accepted while o_ready is high; a finished word is held until the downstream consumer takes it.
module deserializer_fsm #(
  parameter int LENGTH    = 24,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_overrun
);

  localparam int CW = $clog2(LENGTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [LENGTH-1:0] r_word;
  logic [LENGTH-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overrun;

  logic              w_accept;
  logic              w_last;
  logic [CW-1:0]     w_pos;
  logic [LENGTH-1:0] w_word_next;

  // i_rst is folded in so o_ready reads 0 during reset without waiting for a clock.
  assign o_ready      = i_rst & i_en & (r_state != VALID);
  assign w_accept     = i_din_valid & o_ready;
  assign w_last       = (r_cnt == CW'(LENGTH - 1));
  assign w_pos        = MSB_FIRST ? (CW'(LENGTH - 1) - r_cnt) : r_cnt;

  assign ov_dout      = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_overrun    = r_overrun;

  // Partial word with the incoming bit merged in, so the final bit lands directly in r_dout.
  always_comb begin
    w_word_next        = r_word;
    w_word_next[w_pos] = i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= (r_state == VALID) && i_en && i_din_valid;
      case (r_state)
        IDLE, SHIFT: begin
          if (w_accept) begin
            if (w_last) begin
              r_state      <= VALID;
              r_dout       <= w_word_next;
              r_dout_valid <= 1'b1;
              r_cnt        <= '0;
              r_word       <= '0;
            end else begin
              r_state <= SHIFT;
              r_cnt   <= r_cnt + CW'(1);
              r_word  <= w_word_next;
            end
          end
        end
        VALID: begin
          if (i_ready) begin
            r_state      <= IDLE;
            r_dout_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// tb/tb_deserializer_fsm.sv - directed bench for deserializer_fsm
// A 4-bit instance runs a cycle table; two 24-bit instances (LSB/MSB first) share the hand-written sequences.
`timescale 1ns/1ps
module tb_deserializer_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic dv = 1'b0;
  logic rdy = 1'b0;

  logic        s_ready, s_valid, s_ovr;
  logic [3:0]  s_dout;
  logic        a_ready, a_valid, a_ovr;
  logic [23:0] a_dout;
  logic        b_ready, b_valid, b_ovr;
  logic [23:0] b_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  deserializer_fsm #(.LENGTH(4), .MSB_FIRST(1'b0)) u_small (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(dv),
    .o_ready(s_ready), .ov_dout(s_dout), .o_dout_valid(s_valid),
    .i_ready(rdy), .o_overrun(s_ovr)
  );

  deserializer_fsm #(.LENGTH(24), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(dv),
    .o_ready(a_ready), .ov_dout(a_dout), .o_dout_valid(a_valid),
    .i_ready(rdy), .o_overrun(a_ovr)
  );

  deserializer_fsm #(.LENGTH(24), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(dv),
    .o_ready(b_ready), .ov_dout(b_dout), .o_dout_valid(b_valid),
    .i_ready(rdy), .o_overrun(b_ovr)
  );

  typedef struct {
    logic       rst, en, dv, din, rdy;
    logic       e_ready, e_valid, e_ovr;
    logic [3:0] e_dout;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rev24(input logic [23:0] x);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = x[23-i];
    return r;
  endfunction

  // Drives one serial word; optional idle slot every third cycle and a 5-cycle enable pause.
  task automatic send_word(input logic [23:0] w, input bit msb, input bit gaps,
                           input int pause_after, input int nbits);
    int   slot;
    logic b;
    slot = 0;
    for (int n = 0; n < nbits; n++) begin
      b = msb ? w[23-n] : w[n];
      if (gaps && (slot % 3 == 2)) begin
        en = 1'b1; dv = 1'b0; din = ~b;
        tick();
        slot++;
      end
      en = 1'b1; dv = 1'b1; din = b;
      @(negedge clk);
      chk("bit_ready_lsb", a_ready, 1'b1);
      chk("bit_ready_msb", b_ready, 1'b1);
      chk("bit_no_valid", a_valid, 1'b0);
      tick();
      slot++;
      if (n + 1 == pause_after) begin
        for (int p = 0; p < 5; p++) begin
          en = 1'b0; dv = 1'b1; din = ~b;
          @(negedge clk);
          chk("pause_ready", a_ready, 1'b0);
          tick();
        end
      end
    end
    en = 1'b1; dv = 1'b0; din = 1'b0;
  endtask

  task automatic expect_word(input string nm, input logic [23:0] w);
    @(negedge clk);
    chk({nm, "_valid"}, a_valid, 1'b1);
    chk({nm, "_dout_lsb"}, a_dout, w);
    chk({nm, "_dout_msb"}, b_dout, rev24(w));
    tick();
  endtask

  // Must be entered just after a rising edge; reset is applied mid-cycle.
  task automatic async_reset();
    dv = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_ovr", a_ovr, 1'b0);
    chk("rst_dout_lsb", a_dout, 24'h0);
    chk("rst_dout_msb", b_dout, 24'h0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    //           rst en dv din rdy  ready valid ovr dout
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hC};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hC};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};

    #1 rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; dv = tbl[i].dv; din = tbl[i].din; rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ovr", i), s_ovr, tbl[i].e_ovr);
      chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].e_dout);
      tick();
    end

    async_reset();

    // LSB-first word, then a back-to-back word: valid one cycle, one word per 25 cycles.
    rdy = 1'b1;
    send_word(24'hFF00FF, 1'b0, 1'b0, -1, 24);
    expect_word("w_ff00ff", 24'hFF00FF);
    send_word(24'h5A5A5A, 1'b0, 1'b0, -1, 24);
    expect_word("w_5a5a5a", 24'h5A5A5A);

    // Pending word held against back-pressure while bits keep arriving.
    rdy = 1'b0;
    send_word(24'h00FF00, 1'b0, 1'b0, -1, 24);
    for (int k = 0; k < 10; k++) begin
      en = 1'b1; dv = 1'b1; din = 1'b1; rdy = 1'b0;
      @(negedge clk);
      chk("hold_valid", a_valid, 1'b1);
      chk("hold_dout", a_dout, 24'h00FF00);
      chk("hold_ready", a_ready, 1'b0);
      chk("hold_ovr", a_ovr, (k == 0) ? 1'b0 : 1'b1);
      tick();
    end
    rdy = 1'b1; dv = 1'b0;
    @(negedge clk);
    chk("consume_ovr", a_ovr, 1'b1);
    chk("consume_valid", a_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("post_valid", a_valid, 1'b0);
    chk("post_ready", a_ready, 1'b1);
    chk("post_ovr", a_ovr, 1'b0);
    chk("post_dout_kept", a_dout, 24'h00FF00);
    tick();
    send_word(24'h3C96E1, 1'b0, 1'b0, -1, 24);
    expect_word("w_3c96e1", 24'h3C96E1);

    // Idle slots and an enable pause must not drop or duplicate bits.
    send_word(24'hAF5EB9, 1'b0, 1'b1, 12, 24);
    expect_word("w_gaps", 24'hAF5EB9);

    // Reset mid-word discards the partial bits.
    send_word(24'hABCDEF, 1'b0, 1'b0, -1, 10);
    async_reset();
    send_word(24'h123456, 1'b0, 1'b0, -1, 24);
    expect_word("w_123456", 24'h123456);

    // MSB-first stream: the MSB_FIRST=1 instance reassembles the word.
    send_word(24'hAF5EB9, 1'b1, 1'b0, -1, 24);
    @(negedge clk);
    chk("msb_valid", b_valid, 1'b1);
    chk("msb_dout", b_dout, 24'hAF5EB9);
    chk("msb_dout_lsbinst", a_dout, rev24(24'hAF5EB9));
    tick();

    // Loopback of random words from a serializer model.
    for (int k = 0; k < 100; k++) begin
      w = 24'($urandom);
      send_word(w, 1'b0, 1'($urandom_range(0, 1)), -1, 24);
      expect_word("loop", w);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
